// File: rtl/request_rr_arbiter_if.sv
// Bundle of requester-side and downstream-side signals for request_rr_arbiter.
// slave: arbiter view; master: view of the logic driving requesters and sink.
interface request_rr_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 16
);
  localparam int unsigned SRC_W = $clog2(NUM_REQ);

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  id;
    logic        valid;
  } request_t;

  request_t [NUM_REQ-1:0] req_in;
  logic     [NUM_REQ-1:0] req_valid;
  logic     [NUM_REQ-1:0] req_ready;
  logic     [NUM_REQ-1:0] req_en;
  request_t               out_req;
  logic     [SRC_W-1:0]   out_src;
  logic                   out_valid;
  logic                   out_ready;
  logic     [CNT_W-1:0]   grant_cnt;

  modport slave (
    input  req_in, req_valid, req_en, out_ready,
    output req_ready, out_req, out_src, out_valid, grant_cnt
  );

  modport master (
    output req_in, req_valid, req_en, out_ready,
    input  req_ready, out_req, out_src, out_valid, grant_cnt
  );
endinterface

// File: rtl/request_rr_arbiter.sv
// Round-robin arbiter: NUM_REQ valid/ready requesters share one registered
// output stage. Priority rotates to the index after the last accepted winner.
// Optional grant statistics counter: define REQUEST_RR_ARBITER_GRANT_CNT_EN.
module request_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  request_rr_arbiter_if.slave  bus
);
  localparam int unsigned SRC_W = $clog2(NUM_REQ);
  localparam int unsigned REQ_W = 21;

  logic [NUM_REQ-1:0] eligible;
  logic               load;
  logic               grant_any;
  logic [SRC_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;

  logic [REQ_W-1:0]   out_req_q,   out_req_d;
  logic [SRC_W-1:0]   out_src_q,   out_src_d;
  logic               out_valid_q, out_valid_d;
  logic [SRC_W-1:0]   ptr_q,       ptr_d;

  assign eligible = bus.req_valid & bus.req_en;
  assign load     = !out_valid_q || bus.out_ready;

  // Pick the first eligible requester scanning from ptr_q upward, wrapping.
  always_comb begin
    int unsigned idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && eligible[SRC_W'(idx)]) begin
        grant_any = 1'b1;
        grant_idx = SRC_W'(idx);
      end
    end
  end

  // One-hot acceptance towards the requesters; silenced while in reset.
  always_comb begin
    grant = '0;
    if (grant_any) grant[grant_idx] = 1'b1;
    bus.req_ready = (rst_n && load) ? grant : '0;
  end

  // Output stage and priority pointer next-state.
  always_comb begin
    out_req_d   = out_req_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (grant_any) begin
        out_valid_d = 1'b1;
        out_req_d   = bus.req_in[grant_idx];
        out_src_d   = grant_idx;
        ptr_d       = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_req_q   <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_req_q   <= out_req_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_req   = out_req_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_valid = out_valid_q;

`ifdef REQUEST_RR_ARBITER_GRANT_CNT_EN
  logic [CNT_W-1:0] grant_cnt_q;

  // Count every acceptance, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
    end else if (load && grant_any) begin
      grant_cnt_q <= grant_cnt_q + 1'b1;
    end
  end

  assign bus.grant_cnt = grant_cnt_q;
`else
  assign bus.grant_cnt = {CNT_W{1'b0}};
`endif
endmodule
